irf_write_port: RTL and testbench

//  Write side of the integer register file: the storage the IRF read muxes select from.

---
 rtl/irf_write_port_pkg.sv | 19 +
 rtl/irf_write_port_reg.sv | 22 ++
 rtl/irf_write_port.sv | 84 ++++++++
 tb/tb_irf_write_port.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/irf_write_port_pkg.sv
// Shared IRF constants and small helpers.
// The read-mux instances import the same constants, so both sides of the
// register file agree on register width, register count and zero-register policy.
package irf_write_port_pkg;

    localparam int IRF_DATA_WIDTH = 8;
    localparam int IRF_ADDR_WIDTH = 3;
    localparam int IRF_NREG       = 2 ** IRF_ADDR_WIDTH;
    localparam bit IRF_ZERO_REG   = 1'b1;

    // Width of the committed-write counter. It wraps from 255 back to 0.
    localparam int IRF_COUNT_WIDTH = 8;

    // True when a write targets the hardwired zero register and must be dropped.
    function automatic logic is_zero_dest(input logic zero_reg_en, input logic addr_is_zero);
        return zero_reg_en & addr_is_zero;
    endfunction

endpackage

// File: rtl/irf_write_port_reg.sv
// One register of the IRF.
// It has a synchronous active-low reset and a load enable.
module irf_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear on reset. Otherwise take d when load is high and hold when it is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/irf_write_port.sv
// IRF write port.
// Each write request is captured into a one-entry pending stage. The pending write
// commits into the register array on the following edge. While a write is pending,
// it is exported on wb_* so that readers can forward it.
//
// Request protocol: "we" is a valid with no ready. Every cycle with we=1 and flush=0
// is accepted unconditionally, so the port never stalls. flush=1 kills the pending
// write and also ignores any request presented in the same cycle.
//
// Forwarding rule for readers: if wb_pending && wb_addr == raddr, use wb_data.
// Otherwise, use regs_flat.
module irf_write_port
    import irf_write_port_pkg::*;
#(
    parameter int DATA_WIDTH = IRF_DATA_WIDTH,
    parameter int ADDR_WIDTH = IRF_ADDR_WIDTH,
    parameter bit ZERO_REG   = IRF_ZERO_REG,
    localparam int NREG      = 2 ** ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [ADDR_WIDTH-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic                       flush,
    output logic [NREG*DATA_WIDTH-1:0] regs_flat,
    output logic                       wb_pending,
    output logic [ADDR_WIDTH-1:0]      wb_addr,
    output logic [DATA_WIDTH-1:0]      wb_data,
    output logic [IRF_COUNT_WIDTH-1:0] wr_count
);

    logic drop_zero;
    logic commit;

    assign drop_zero = is_zero_dest(ZERO_REG, (waddr == '0));
    assign commit    = wb_pending & ~flush;

    // Pending stage.
    // Addr/data follow every request. The valid bit is set only for writes that survive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_pending <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
        end else begin
            wb_pending <= we & ~flush & ~drop_zero;
            if (we) begin
                wb_addr <= waddr;
                wb_data <= wdata;
            end
        end
    end

    // Count the writes that actually reach the register array.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_count <= '0;
        end else if (commit) begin
            wr_count <= wr_count + 1'b1;
        end
    end

    // Register array: one loadable register per index.
    // Register 0 is tied to zero when the zero-register policy is on.
    for (genvar i = 0; i < NREG; i++) begin : g_reg
        if (ZERO_REG && (i == 0)) begin : g_zero
            assign regs_flat[i*DATA_WIDTH +: DATA_WIDTH] = '0;
        end else begin : g_store
            logic load;
            assign load = commit & (wb_addr == ADDR_WIDTH'(i));
            irf_reg #(
                .WIDTH (DATA_WIDTH)
            ) u_reg (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (load),
                .d     (wb_data),
                .q     (regs_flat[i*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    end

endmodule

// File: tb/tb_irf_write_port.sv
// Bench for irf_write_port.
// It has three parts: a directed vector table, random traffic against an
// array-based reference model, and a counter-wrap sequence.
module tb_irf_write_port;

    localparam int DW   = 8;
    localparam int AW   = 3;
    localparam int NREG = 8;

    // Clock and reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic                 we;
    logic [AW-1:0]        waddr;
    logic [DW-1:0]        wdata;
    logic                 flush;
    logic [NREG*DW-1:0]   regs_flat;
    logic                 wb_pending;
    logic [AW-1:0]        wb_addr;
    logic [DW-1:0]        wb_data;
    logic [7:0]           wr_count;

    irf_write_port dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .flush      (flush),
        .regs_flat  (regs_flat),
        .wb_pending (wb_pending),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .wr_count   (wr_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Driver: present the inputs, take one edge, then settle a little past the edge.
    task automatic drive(input logic r, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic f);
        rst_n = r; we = w; waddr = a; wdata = d; flush = f;
        @(posedge clk);
        #1;
    endtask

    // Directed vector table
    typedef struct {
        logic          rst_n;
        logic          we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          flush;
        logic          chk_wb;
        logic          exp_pend;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        logic [63:0]   exp_flat;
        logic [7:0]    exp_cnt;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vec [NVEC];

    // Reference model: a plain register array plus a pending slot
    logic [DW-1:0] m_regs [NREG];
    logic          m_pend;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            m_cnt;
    logic [63:0]   exp_q [$];

    task automatic model_edge(input logic r, input logic w, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic f);
        logic [63:0] flat;
        if (!r) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_pend = 0; m_addr = '0; m_data = '0; m_cnt = 0;
        end else begin
            if (m_pend && !f) begin
                m_regs[m_addr] = m_data;
                m_cnt = (m_cnt + 1) % 256;
            end
            if (w) begin
                m_addr = a;
                m_data = d;
            end
            m_pend = w && !f && (a != 0);
        end
        flat = '0;
        for (int i = 0; i < NREG; i++) flat[i*DW +: DW] = m_regs[i];
        exp_q.push_back(flat);
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; flush = 1'b0;

        //            rst we a  data   fl  chk pend a  data   flat                     cnt
        vec[0]  = '{1'b0, 1'b1, 3'd3, 8'hA5, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 64'h0, 8'd0};
        vec[1]  = '{1'b0, 1'b1, 3'd3, 8'hA5, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 64'h0, 8'd0};
        vec[2]  = '{1'b1, 1'b1, 3'd3, 8'hA5, 1'b0, 1'b1, 1'b1, 3'd3, 8'hA5, 64'h0, 8'd0};
        vec[3]  = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd3, 8'hA5, 64'h00000000A5000000, 8'd1};
        vec[4]  = '{1'b1, 1'b1, 3'd5, 8'h11, 1'b0, 1'b1, 1'b1, 3'd5, 8'h11, 64'h00000000A5000000, 8'd1};
        vec[5]  = '{1'b1, 1'b1, 3'd5, 8'h22, 1'b0, 1'b1, 1'b1, 3'd5, 8'h22, 64'h00001100A5000000, 8'd2};
        vec[6]  = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd5, 8'h22, 64'h00002200A5000000, 8'd3};
        vec[7]  = '{1'b1, 1'b1, 3'd0, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 64'h00002200A5000000, 8'd3};
        vec[8]  = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 64'h00002200A5000000, 8'd3};
        vec[9]  = '{1'b1, 1'b1, 3'd2, 8'h7E, 1'b0, 1'b1, 1'b1, 3'd2, 8'h7E, 64'h00002200A5000000, 8'd3};
        vec[10] = '{1'b1, 1'b1, 3'd4, 8'h99, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 64'h00002200A5000000, 8'd3};
        vec[11] = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 64'h00002200A5000000, 8'd3};
        vec[12] = '{1'b1, 1'b1, 3'd6, 8'hC3, 1'b0, 1'b1, 1'b1, 3'd6, 8'hC3, 64'h00002200A5000000, 8'd3};
        vec[13] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 64'h0, 8'd0};

        @(negedge clk);

        // Directed rows: reset, write, back-to-back, zero reg, flush, reset mid-pending
        for (int i = 0; i < NVEC; i++) begin
            drive(vec[i].rst_n, vec[i].we, vec[i].waddr, vec[i].wdata, vec[i].flush);
            check($sformatf("vec%0d regs_flat", i), regs_flat, vec[i].exp_flat);
            check($sformatf("vec%0d wb_pending", i), 64'(wb_pending), 64'(vec[i].exp_pend));
            check($sformatf("vec%0d wr_count", i), 64'(wr_count), 64'(vec[i].exp_cnt));
            if (vec[i].chk_wb) begin
                check($sformatf("vec%0d wb_addr", i), 64'(wb_addr), 64'(vec[i].exp_addr));
                check($sformatf("vec%0d wb_data", i), 64'(wb_data), 64'(vec[i].exp_data));
            end
        end

        // Random traffic against the model. It starts from a reset so both sides agree.
        model_edge(1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        void'(exp_q.pop_front());
        for (int c = 0; c < 400; c++) begin
            logic          r, w, f;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            r = ($urandom_range(0, 63) != 0);
            w = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 7) == 0);
            a = AW'($urandom_range(0, NREG - 1));
            d = DW'($urandom);
            model_edge(r, w, a, d, f);
            drive(r, w, a, d, f);
            check($sformatf("rnd%0d regs_flat", c), regs_flat, exp_q.pop_front());
            check($sformatf("rnd%0d wb_pending", c), 64'(wb_pending), 64'(m_pend));
            check($sformatf("rnd%0d wr_count", c), 64'(wr_count), 64'(m_cnt));
            if (m_pend) begin
                check($sformatf("rnd%0d wb_addr", c), 64'(wb_addr), 64'(m_addr));
                check($sformatf("rnd%0d wb_data", c), 64'(wb_data), 64'(m_data));
            end
        end

        // Counter wrap: 256 back-to-back writes to reg1, then one idle cycle.
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        for (int k = 0; k < 256; k++) drive(1'b1, 1'b1, 3'd1, 8'(k), 1'b0);
        check("wrap count at 255", 64'(wr_count), 64'd255);
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        check("wrap count at 0", 64'(wr_count), 64'd0);
        check("wrap reg1 last value", 64'(regs_flat[1*DW +: DW]), 64'hFF);
        check("wrap pending cleared", 64'(wb_pending), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
